// File: rtl/pol_act_stage.sv
// pol_act_stage: activation stage feeding pooling; applies per-frame latched activation to readout words, tags window ends, buffers two results behind a valid/ready handshake (optional leaky ReLU on act_s=4 via POL_ACT_LEAKY_EN)
module pol_act_stage #(
  parameter int DW = 16,
  parameter int FRAME_LEN = 16,
  parameter int CAP = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 eact,
  input  logic [2:0]           act_s,
  input  logic                 q_valid,
  output logic                 q_ready,
  input  logic signed [DW-1:0] q,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic signed [DW-1:0] a_data,
  output logic                 a_last,
  output logic [7:0]           frame_idx
);
  localparam logic signed [DW-1:0] CAP_V = DW'(CAP);
  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);
  logic [1:0] cnt;
  logic signed [DW-1:0] d0, d1, y, y_relu, y_clamp, y_half, y_leaky;
  logic l0, l1, eact_l, acc, pop, first, last_in, e_eff, neg;
  logic [2:0] act_l, s_eff;
  assign q_ready = !rst && !cnt[1];
  assign a_valid = cnt != 2'd0;
  assign a_data = d0;
  assign a_last = l0;
  assign acc = q_valid && q_ready;
  assign pop = a_valid && a_ready;
  assign first = frame_idx == 8'd0;
  assign last_in = frame_idx == LAST_IDX;
  assign e_eff = first ? eact : eact_l;
  assign s_eff = first ? act_s : act_l;
  assign neg = q[DW-1];
  assign y_relu = neg ? '0 : q;
  assign y_clamp = neg ? '0 : (q > CAP_V ? CAP_V : q);
  assign y_half = neg ? '0 : q >>> 1;
`ifdef POL_ACT_LEAKY_EN
  assign y_leaky = neg ? q >>> 3 : q;
`else
  assign y_leaky = q;
`endif
  always_comb begin
    y = !e_eff ? q :
        s_eff == 3'd1 ? y_relu :
        s_eff == 3'd2 ? y_clamp :
        s_eff == 3'd3 ? y_half :
        s_eff == 3'd4 ? y_leaky : q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      d0 <= '0;
      d1 <= '0;
      l0 <= 1'b0;
      l1 <= 1'b0;
      frame_idx <= '0;
      eact_l <= 1'b0;
      act_l <= '0;
    end else begin
      cnt <= cnt + 2'(acc) - 2'(pop);
      if (pop) begin
        d0 <= d1;
        l0 <= l1;
      end
      // a push lands in the head slot when the buffer is, or is becoming, empty at the head
      if (acc && (cnt == 2'd0 || pop)) begin
        d0 <= y;
        l0 <= last_in;
      end else if (acc) begin
        d1 <= y;
        l1 <= last_in;
      end
      if (acc) frame_idx <= last_in ? 8'd0 : frame_idx + 8'd1;
      if (acc && first) begin
        eact_l <= eact;
        act_l <= act_s;
      end
    end
  end
endmodule

// File: tb/tb_pol_act_stage.sv
// tb_pol_act_stage: table-driven and scoreboard bench for pol_act_stage with FRAME_LEN=4
module tb_pol_act_stage;
  logic clk = 0, rst = 1, eact = 0, q_valid = 0, a_ready = 0;
  logic [2:0] act_s = 0;
  logic signed [15:0] q = 0;
  logic q_ready, a_valid, a_last;
  logic signed [15:0] a_data;
  logic [7:0] frame_idx;
  int n_cmp = 0, n_fail = 0, idx = 0;
  typedef struct {logic signed [15:0] d; logic l;} exp_t;
  typedef struct {logic signed [15:0] q; logic e; logic [2:0] s; logic signed [15:0] y; logic l;} vec_t;
  exp_t sb[$];
  vec_t tv[$];
  pol_act_stage #(.DW(16), .FRAME_LEN(4), .CAP(4095)) dut (
    .clk(clk), .rst(rst), .eact(eact), .act_s(act_s), .q_valid(q_valid), .q_ready(q_ready),
    .q(q), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last), .frame_idx(frame_idx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic add(input int qv, input logic e, input logic [2:0] s, input int y, input logic l);
    vec_t v;
    v.q = 16'(qv); v.e = e; v.s = s; v.y = 16'(y); v.l = l;
    tv.push_back(v);
  endtask
  task automatic cyc(input logic qv, input logic signed [15:0] qd, input logic e, input logic [2:0] s,
                     input logic ar, input logic signed [15:0] ed, input logic el, output logic accepted);
    exp_t x;
    @(negedge clk);
    q_valid = qv; q = qd; eact = e; act_s = s; a_ready = ar;
    #1;
    chk("frame_idx", int'(frame_idx), idx);
    accepted = q_valid && q_ready;
    if (a_valid && a_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        x = sb.pop_front();
        chk("a_data", int'(a_data), int'(x.d));
        chk("a_last", int'(a_last), int'(x.l));
      end
    end
    if (accepted) begin
      x.d = ed; x.l = el;
      sb.push_back(x);
      idx = (idx + 1) % 4;
    end
    @(posedge clk);
  endtask
  initial begin
    logic ok;
    int n_acc;
    logic signed [15:0] qn;
    // ReLU sweep padded to two frames
    add(-5, 1, 1, 0, 0); add(0, 1, 1, 0, 0); add(7, 1, 1, 7, 0); add(-32768, 1, 1, 0, 1);
    add(32767, 1, 1, 32767, 0); add(-1, 1, 1, 0, 0); add(2, 1, 1, 2, 0); add(3, 1, 1, 3, 1);
    // clamp, then half-ReLU
    add(5000, 1, 2, 4095, 0); add(4095, 1, 2, 4095, 0); add(-1, 1, 2, 0, 0); add(100, 1, 2, 100, 1);
    add(9, 1, 3, 4, 0); add(-9, 1, 3, 0, 0); add(3, 1, 3, 1, 0); add(-4, 1, 3, 0, 1);
    // config latch: act_s change mid-frame ignored until next frame
    add(-3, 1, 1, 0, 0); add(-3, 1, 1, 0, 0); add(-3, 1, 0, 0, 0); add(-3, 1, 0, 0, 1);
    add(-3, 1, 0, -3, 0); add(-3, 1, 0, -3, 0); add(-3, 1, 1, -3, 0); add(-3, 1, 1, -3, 1);
`ifdef POL_ACT_LEAKY_EN
    add(-16, 1, 4, -2, 0); add(20, 1, 4, 20, 0); add(-1, 1, 4, -1, 0); add(-7, 1, 4, -1, 1);
`else
    add(-16, 1, 4, -16, 0); add(20, 1, 4, 20, 0); add(-1, 1, 4, -1, 0); add(-7, 1, 4, -7, 1);
`endif
    // eact=0 latched: pass-through, mid-frame eact rise ignored
    add(-5, 0, 1, -5, 0); add(-6, 1, 1, -6, 0); add(4, 1, 2, 4, 0); add(-1, 1, 1, -1, 1);
    // bypass selects
    add(-100, 1, 7, -100, 0); add(-1, 1, 5, -1, 0); add(50, 1, 6, 50, 0); add(32767, 1, 0, 32767, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst q_ready", int'(q_ready), 0);
    chk("rst a_valid", int'(a_valid), 0);
    chk("rst a_data", int'(a_data), 0);
    chk("rst a_last", int'(a_last), 0);
    chk("rst frame_idx", int'(frame_idx), 0);
    rst = 0;
    foreach (tv[i]) begin
      ok = 0;
      for (int k = 0; k < 5 && !ok; k++) cyc(1, tv[i].q, tv[i].e, tv[i].s, 1, tv[i].y, tv[i].l, ok);
      if (!ok) chk("accept_timeout", 0, 1);
      cyc(0, 0, 0, 0, 1, 0, 0, ok);
      chk("latency", sb.size(), 0);
    end
    // backpressure with pass-through stream
    qn = 11; n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1, qn, 0, 0, 0, qn, idx == 3, ok);
      if (ok) begin n_acc++; qn++; end
    end
    chk("bp accepts", n_acc, 2);
    @(negedge clk);
    #1;
    chk("bp q_ready", int'(q_ready), 0);
    chk("bp a_data hold", int'(a_data), 11);
    chk("bp a_valid", int'(a_valid), 1);
    cyc(0, 0, 0, 0, 1, 0, 0, ok);
    @(negedge clk);
    q_valid = 0; a_ready = 0;
    #1;
    chk("q_ready after pop", int'(q_ready), 1);
    chk("head after pop", int'(a_data), 12);
    // simultaneous push and pop at count 1
    cyc(1, qn, 0, 0, 1, qn, idx == 3, ok); chk("sim accept 1", int'(ok), 1); qn++;
    cyc(1, qn, 0, 0, 1, qn, idx == 3, ok); chk("sim accept 2", int'(ok), 1); qn++;
    for (int k = 0; k < 5 && sb.size() > 0; k++) cyc(0, 0, 0, 0, 1, 0, 0, ok);
    chk("drained", sb.size(), 0);
    @(negedge clk);
    a_ready = 0;
    #1;
    chk("drained a_valid", int'(a_valid), 0);
    // reset mid-frame with two buffered words
    for (int k = 0; k < 2; k++) cyc(1, -50, 1, 1, 0, 0, 0, ok);
    @(negedge clk);
    q_valid = 0;
    #1;
    chk("pre-rst frame_idx", int'(frame_idx), 2);
    chk("pre-rst q_ready", int'(q_ready), 0);
    rst = 1;
    #1;
    chk("in-rst q_ready", int'(q_ready), 0);
    @(negedge clk);
    #1;
    chk("post-rst a_valid", int'(a_valid), 0);
    chk("post-rst frame_idx", int'(frame_idx), 0);
    rst = 0;
    sb.delete();
    idx = 0;
    cyc(1, -50, 0, 0, 1, -50, 0, ok); chk("relatch accept", int'(ok), 1);
    cyc(1, -60, 1, 1, 1, -60, 0, ok); chk("relatch accept 2", int'(ok), 1);
    for (int k = 0; k < 5 && sb.size() > 0; k++) cyc(0, 0, 0, 0, 1, 0, 0, ok);
    chk("final drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
